demux4_stream: RTL and testbench

DEMUX4_STREAM -- requirements
Module: demux4_stream

---
 rtl/demux4_stream.sv | 171 +++++++++++++++++
 tb/tb_demux4_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// -----------------------------------------------------------------------------
// demux4_stream
//
// Splits one 8-bit valid/ready stream into four single-entry registered
// channels of width 4 (a), 6 (b), 7 (c) and 8 (d). Each incoming word is
// steered by in_sel. The selected channel keeps the low W bits of the word and
// flags overflow when any dropped upper bit was set. Each channel drains
// independently and counts the words it has delivered.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    synchronous active-low reset
//   in_data[7:0]             source word
//   in_sel[1:0]              destination: 0=a, 1=b, 2=c, 3=d
//   in_valid / in_ready      source handshake (in_ready is combinational)
//   a[3:0] b[5:0] c[6:0] d[7:0]  channel data registers
//   X_valid / X_ready        per-channel sink handshake
//   a_ovf b_ovf c_ovf        dropped upper bits of the held word were non-zero
//   cnt_a..cnt_d[CNT_W-1:0]  words delivered per channel (wrapping)
// -----------------------------------------------------------------------------
module demux4_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [7:0]       in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,

    output logic [3:0]       a,
    output logic [5:0]       b,
    output logic [6:0]       c,
    output logic [7:0]       d,

    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,

    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,

    output logic             a_ovf,
    output logic             b_ovf,
    output logic             c_ovf,

    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    // Channel index order everywhere below: 0=a, 1=b, 2=c, 3=d.
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       ready_vec;
    logic [3:0]       load;
    logic [3:0]       drain;

    logic [3:0]       a_q, a_d;
    logic [5:0]       b_q, b_d;
    logic [6:0]       c_q, c_d;
    logic [7:0]       d_q, d_d;
    logic [2:0]       ovf_q, ovf_d;          // a, b, c only; d cannot overflow

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d_v [4];

    assign ready_vec = {d_ready, c_ready, b_ready, a_ready};
    assign drain     = valid_q & ready_vec;

    // Only the addressed channel decides in_ready, so a stalled channel never
    // blocks words headed elsewhere. A full channel whose sink is accepting
    // this cycle frees its slot at the same edge, so it can take a new word.
    // NOTE: every signal driven from always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = !valid_q[in_sel] || ready_vec[in_sel];
        end
    end

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    // A load wins over a drain: simultaneous drain+load keeps the channel
    // full with the new word, giving back-to-back throughput with no bubble.
    assign valid_d = load | (valid_q & ~drain);

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        d_d   = d_q;
        ovf_d = ovf_q;
        if (load[0]) begin
            a_d      = in_data[3:0];
            ovf_d[0] = |in_data[7:4];
        end
        if (load[1]) begin
            b_d      = in_data[5:0];
            ovf_d[1] = |in_data[7:6];
        end
        if (load[2]) begin
            c_d      = in_data[6:0];
            ovf_d[2] = in_data[7];
        end
        if (load[3]) begin
            d_d      = in_data;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d_v[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, drain[i]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    // NOTE: the data and overflow registers are reset too (not only the valid
    // bits), so the outputs read as zero after reset, not stale words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d_v[i];
            end
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign c       = c_q;
    assign d       = d_q;
    assign a_valid = valid_q[0];
    assign b_valid = valid_q[1];
    assign c_valid = valid_q[2];
    assign d_valid = valid_q[3];
    assign a_ovf   = ovf_q[0];
    assign b_ovf   = ovf_q[1];
    assign c_ovf   = ovf_q[2];
    assign cnt_a   = cnt_q[0];
    assign cnt_b   = cnt_q[1];
    assign cnt_c   = cnt_q[2];
    assign cnt_d   = cnt_q[3];

endmodule

// File: tb/tb_demux4_stream.sv
// -----------------------------------------------------------------------------
// tb_demux4_stream
//
// Bench for demux4_stream. A per-channel scoreboard queue receives the
// expected {data, ovf} whenever a word is accepted and is popped when the
// channel delivers. A small reference model predicts in_ready, the valid bits
// and the counters. Stimulus: a vector table, hand-written multi-cycle
// sequences and a stretch of random traffic with random sink back-pressure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux4_stream;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rdy;

    logic [3:0] a;
    logic [5:0] b;
    logic [6:0] c;
    logic [7:0] d;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ovf, b_ovf, c_ovf;
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;

    exp_t       sbq [4][$];
    logic [7:0] mcnt [4];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #10 clk = ~clk;

    demux4_stream #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .a_ready  (rdy[0]),
        .b_ready  (rdy[1]),
        .c_ready  (rdy[2]),
        .d_ready  (rdy[3]),
        .a_ovf    (a_ovf),
        .b_ovf    (b_ovf),
        .c_ovf    (c_ovf),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
        .cnt_d    (cnt_d)
    );

    function automatic logic [7:0] ch_data(input int i);
        case (i)
            0:       return {4'b0, a};
            1:       return {2'b0, b};
            2:       return {1'b0, c};
            default: return d;
        endcase
    endfunction

    function automatic logic ch_valid(input int i);
        case (i)
            0:       return a_valid;
            1:       return b_valid;
            2:       return c_valid;
            default: return d_valid;
        endcase
    endfunction

    function automatic logic ch_ovf(input int i);
        case (i)
            0:       return a_ovf;
            1:       return b_ovf;
            2:       return c_ovf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] ch_cnt(input int i);
        case (i)
            0:       return cnt_a;
            1:       return cnt_b;
            2:       return cnt_c;
            default: return cnt_d;
        endcase
    endfunction

    // Reference truncation: keep the low W bits, flag any dropped bit.
    function automatic exp_t mk_exp(input logic [1:0] s, input logic [7:0] x);
        exp_t       e;
        int         w;
        logic [7:0] mask;
        case (s)
            2'd0:    w = 4;
            2'd1:    w = 6;
            2'd2:    w = 7;
            default: w = 8;
        endcase
        mask   = 8'hFF >> (8 - w);
        e.data = x & mask;
        e.ovf  = (x & ~mask) != 8'h00;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle. Compares DUT state against the model at the falling
    // edge, updates the model for what the rising edge will do, then returns
    // 1 ns after the rising edge so the caller can drive the next inputs.
    task automatic tick(input exp_t ld, output bit acc);
        bit exp_rdy;
        acc = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            check("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                sbq[i].delete();
                mcnt[i] = 8'd0;
            end
            return;
        end
        exp_rdy = (sbq[in_sel].size() == 0) || rdy[in_sel];
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("valid_%0d", i), {31'b0, ch_valid(i)},
                  {31'b0, sbq[i].size() != 0});
            check($sformatf("cnt_%0d", i), {24'b0, ch_cnt(i)}, {24'b0, mcnt[i]});
            if (sbq[i].size() != 0) begin
                check($sformatf("data_%0d", i), {24'b0, ch_data(i)},
                      {24'b0, sbq[i][0].data});
                if (i != 3) begin
                    check($sformatf("ovf_%0d", i), {31'b0, ch_ovf(i)},
                          {31'b0, sbq[i][0].ovf});
                end
                if (rdy[i]) begin
                    void'(sbq[i].pop_front());
                    mcnt[i] = mcnt[i] + 8'd1;
                end
            end
        end
        if (in_valid && exp_rdy) begin
            sbq[in_sel].push_back(ld);
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_sel  = 2'($urandom_range(0, 3));
            in_data = 8'($urandom);
            tick('0, acc);
        end
    endtask

    // Offers one word until accepted; an expired budget counts as a failure.
    task automatic send(input logic [1:0] s, input logic [7:0] x, input exp_t e);
        bit acc;
        int n;
        acc      = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = x;
        while (!acc && n < 50) begin
            tick(e, acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: sel %0d data %0h not accepted after %0d cycles", s, x, n);
        end
    endtask

    task automatic do_reset();
        bit acc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick('0, acc);
        tick('0, acc);
        rst_n = 1'b1;
    endtask

    vec_t tbl [8];
    bit   acc;

    initial begin
        tbl[0] = '{2'd0, 8'h0F, 8'h0F, 1'b0};
        tbl[1] = '{2'd0, 8'h10, 8'h00, 1'b1};
        tbl[2] = '{2'd1, 8'h3F, 8'h3F, 1'b0};
        tbl[3] = '{2'd1, 8'h41, 8'h01, 1'b1};
        tbl[4] = '{2'd2, 8'h7F, 8'h7F, 1'b0};
        tbl[5] = '{2'd2, 8'h80, 8'h00, 1'b1};
        tbl[6] = '{2'd3, 8'hFF, 8'hFF, 1'b0};
        tbl[7] = '{2'd3, 8'h00, 8'h00, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_data  = 8'h00;
        rdy      = 4'hF;

        // Reset state: everything cleared.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_valid_%0d", i), {31'b0, ch_valid(i)}, 32'd0);
            check($sformatf("rst_data_%0d", i), {24'b0, ch_data(i)}, 32'd0);
            check($sformatf("rst_ovf_%0d", i), {31'b0, ch_ovf(i)}, 32'd0);
            check($sformatf("rst_cnt_%0d", i), {24'b0, ch_cnt(i)}, 32'd0);
        end

        // 0xFF to a: truncated to 0xF with overflow, drained next cycle.
        send(2'd0, 8'hFF, mk_exp(2'd0, 8'hFF));
        check("a_after_ff", {28'b0, a}, 32'hF);
        check("a_valid_after_ff", {31'b0, a_valid}, 32'd1);
        check("a_ovf_after_ff", {31'b0, a_ovf}, 32'd1);
        idle(1);
        check("a_valid_drained", {31'b0, a_valid}, 32'd0);
        check("cnt_a_one", {24'b0, cnt_a}, 32'd1);

        // d stalled: second word refused until the sink accepts.
        rdy = 4'b0111;
        send(2'd3, 8'hA5, mk_exp(2'd3, 8'hA5));
        in_valid = 1'b1;
        in_sel   = 2'd3;
        in_data  = 8'h5A;
        tick(mk_exp(2'd3, 8'h5A), acc);
        check("d_held", {24'b0, d}, 32'hA5);
        check("d_stall_refuse", {31'b0, in_ready}, 32'd0);
        rdy = 4'hF;
        send(2'd3, 8'h5A, mk_exp(2'd3, 8'h5A));
        check("d_second", {24'b0, d}, 32'h5A);
        idle(2);
        check("cnt_d_two", {24'b0, cnt_d}, 32'd2);

        // Vector table with all sinks ready, back to back.
        for (int v = 0; v < 8; v++) begin
            send(tbl[v].sel, tbl[v].data, '{tbl[v].exp_data, tbl[v].exp_ovf});
        end
        idle(2);

        // c stalled does not block b.
        rdy = 4'b1011;
        send(2'd2, 8'h12, mk_exp(2'd2, 8'h12));
        send(2'd1, 8'h3F, mk_exp(2'd1, 8'h3F));
        check("b_3f", {26'b0, b}, 32'h3F);
        check("b_ovf_3f", {31'b0, b_ovf}, 32'd0);
        check("c_unchanged", {25'b0, c}, 32'h12);
        check("c_valid_held", {31'b0, c_valid}, 32'd1);

        // Simultaneous drain and load of b: no bubble.
        send(2'd1, 8'h41, mk_exp(2'd1, 8'h41));
        check("b_valid_kept", {31'b0, b_valid}, 32'd1);
        check("b_41", {26'b0, b}, 32'h01);
        check("b_ovf_41", {31'b0, b_ovf}, 32'd1);
        idle(1);

        // Reset while c holds a word, with in_valid asserted during reset.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 2'd3;
        in_data  = 8'h77;
        tick('0, acc);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("c_valid_rst", {31'b0, c_valid}, 32'd0);
        check("c_rst", {25'b0, c}, 32'd0);
        check("cnt_c_rst", {24'b0, cnt_c}, 32'd0);
        check("d_valid_rst", {31'b0, d_valid}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check($sformatf("in_ready_after_rst_%0d", s), {31'b0, in_ready}, 32'd1);
        end
        idle(1);

        // 256 words to a: the counter wraps to zero.
        do_reset();
        rdy = 4'hF;
        for (int k = 0; k < 256; k++) begin
            send(2'd0, 8'(k), mk_exp(2'd0, 8'(k)));
        end
        idle(1);
        check("cnt_a_wrap", {24'b0, cnt_a}, 32'd0);

        // Random traffic with random back-pressure.
        for (int k = 0; k < 400; k++) begin
            rdy      = 4'($urandom);
            in_valid = 1'($urandom);
            in_sel   = 2'($urandom);
            in_data  = 8'($urandom);
            tick(mk_exp(in_sel, in_data), acc);
        end
        in_valid = 1'b0;
        rdy      = 4'hF;
        idle(3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("final_empty_%0d", i), {31'b0, ch_valid(i)}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
